// File: rtl/conv1_ofm_writer_if.sv
// -----------------------------------------------------------------------------
// conv1_ofm_writer_if
//
// Bundles the signals between conv1, the layer-1 OFM writer and the RAM
// write port.
//   conv1 side : conv1_sample, conv1_finish, ofm (DSP_NO words), ram_feedback
//   RAM side   : wr_en, wr_addr, wr_data (LANES words)
//   status     : busy, overflow, done, checksum
//
// Modports:
//   master - conv1/producer view: drives sample/finish/ofm, observes the rest.
//   slave  - writer view: consumes sample/finish/ofm, drives the rest.
// -----------------------------------------------------------------------------
interface conv1_ofm_writer_if #(
  parameter int WOUT   = 128,
  parameter int DSP_NO = 64,
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2((DSP_NO / LANES) * WOUT * WOUT)
);

  logic                          conv1_sample;
  logic                          conv1_finish;
  logic [DSP_NO-1:0][WIDTH-1:0]  ofm;
  logic                          ram_feedback;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [LANES*WIDTH-1:0]        wr_data;
  logic                          busy;
  logic                          overflow;
  logic                          done;
  logic [31:0]                   checksum;

  modport master (
    output conv1_sample, conv1_finish, ofm,
    input  ram_feedback, wr_en, wr_addr, wr_data, busy, overflow, done, checksum
  );

  modport slave (
    input  conv1_sample, conv1_finish, ofm,
    output ram_feedback, wr_en, wr_addr, wr_data, busy, overflow, done, checksum
  );

endinterface : conv1_ofm_writer_if

// File: rtl/conv1_ofm_writer.sv
// -----------------------------------------------------------------------------
// conv1_ofm_writer
//
// Consumer end of the conv1 output interface. On each conv1_sample pulse the
// DSP_NO channel words are latched into a holding buffer and drained LANES
// words per cycle into the layer-1 OFM RAM. The RAM is channel-group-major:
//   wr_addr = grp * WOUT*WOUT + pix
// Once every pixel has been stored and conv1_finish is high, ram_feedback
// pulses for one cycle and the block parks in DONE until reset.
//
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset
//   bus   - conv1_ofm_writer_if.slave (conv1 inputs, RAM write port, status)
//
// Optional feature (macro CONV1_WR_CHECKSUM_EN):
//   defined   - checksum is the 32-bit wrapping sum of every WIDTH-bit word
//               written, updated together with the write.
//   undefined - checksum is tied to 0.
// -----------------------------------------------------------------------------
module conv1_ofm_writer #(
  parameter int WOUT   = 128,
  parameter int DSP_NO = 64,
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2((DSP_NO / LANES) * WOUT * WOUT)
) (
  input logic               clk,
  input logic               rst,
  conv1_ofm_writer_if.slave bus
);

  localparam int NPIX   = WOUT * WOUT;
  localparam int GROUPS = DSP_NO / LANES;
  localparam int PIX_W  = $clog2(NPIX) + 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Registered state
  state_t                        state_q;
  logic [GRP_W-1:0]              grp_q;
  logic [PIX_W-1:0]              pix_q;
  logic                          wr_en_q;
  logic [ADDR_W-1:0]             wr_addr_q;
  logic [LANES*WIDTH-1:0]        wr_data_q;
  logic                          ovf_q;
  logic                          fb_q;
  logic [DSP_NO-1:0][WIDTH-1:0]  buffer;

  // Next-state values
  state_t                        state_d;
  logic [GRP_W-1:0]              grp_d;
  logic [PIX_W-1:0]              pix_d;
  logic                          wr_en_d;
  logic [ADDR_W-1:0]             wr_addr_d;
  logic [LANES*WIDTH-1:0]        wr_data_d;
  logic                          ovf_d;
  logic                          fb_d;

  // Datapath control from the FSM
  logic                          load;      // capture ofm into the buffer
  logic                          from_ofm;  // first write comes straight from ofm
  logic [GRP_W-1:0]              sel_grp;   // group placed on the write port next
  logic [IDX_W-1:0]              sel_base;  // first channel of sel_grp

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // Outputs are registered, so this block computes what the write port shows
  // in the *following* cycle: the accept edge already loads group 0, and each
  // DRAIN cycle loads the group after the one currently visible.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    grp_d     = grp_q;
    pix_d     = pix_q;
    ovf_d     = ovf_q;
    fb_d      = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    load      = 1'b0;
    from_ofm  = 1'b0;
    sel_grp   = '0;
    sel_base  = '0;

    case (state_q)
      IDLE: begin
        if (bus.conv1_sample && (pix_q < PIX_W'(NPIX))) begin
          load     = 1'b1;
          from_ofm = 1'b1;
          grp_d    = '0;
          wr_en_d  = 1'b1;
          state_d  = DRAIN;
        end else if ((pix_q == PIX_W'(NPIX)) && bus.conv1_finish) begin
          // Samples arriving once the map is full are silently ignored.
          fb_d    = 1'b1;
          state_d = DONE;
        end
      end

      DRAIN: begin
        // The buffer is busy: any new sample is dropped and flagged.
        if (bus.conv1_sample) begin
          ovf_d = 1'b1;
        end
        if (grp_q == GRP_W'(GROUPS - 1)) begin
          if (pix_q != PIX_W'(NPIX)) begin
            pix_d = pix_q + PIX_W'(1);
          end
          state_d = IDLE;
        end else begin
          grp_d   = grp_q + GRP_W'(1);
          sel_grp = grp_q + GRP_W'(1);
          wr_en_d = 1'b1;
        end
      end

      DONE: begin
        // Terminal until reset.
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Write port is zero whenever no write is issued.
    if (wr_en_d) begin
      sel_base  = IDX_W'(sel_grp) * IDX_W'(LANES);
      wr_addr_d = ADDR_W'(sel_grp) * ADDR_W'(NPIX) + ADDR_W'(pix_q);
      if (from_ofm) begin
        wr_data_d = bus.ofm[LANES-1:0];
      end else begin
        wr_data_d = buffer[sel_base +: LANES];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      pix_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      fb_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      pix_q     <= pix_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      fb_q      <= fb_d;
    end
  end

  // NOTE: the holding buffer has no reset; its contents are only read after a
  // capture, and leaving it unreset lets it map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (load) begin
      buffer <= bus.ofm;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional running checksum of every word written
  // ---------------------------------------------------------------------------
`ifdef CONV1_WR_CHECKSUM_EN
  logic [31:0] csum_q;
  logic [31:0] csum_d;

  always_comb begin
    csum_d = csum_q;
    if (wr_en_d) begin
      for (int l = 0; l < LANES; l++) begin
        csum_d = csum_d + 32'(wr_data_d[l*WIDTH +: WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.ram_feedback = fb_q;
  assign bus.overflow     = ovf_q;
  assign bus.busy         = (state_q == DRAIN);
  assign bus.done         = (state_q == DONE);

endmodule : conv1_ofm_writer
